// File: rtl/cdb_multi_bcast.sv
// rtl/cdb_multi_bcast.sv - multi-lane common data bus: commit queue with registered broadcast drain
module cdb_multi_bcast #(
  parameter int NUM_IN   = 2,
  parameter int NUM_OUT  = 2,
  parameter int DEPTH    = 8,
  parameter int RENAME_W = 4,
  parameter int XLEN     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic [NUM_IN-1:0]            commit_valid,
  input  logic [NUM_IN*XLEN-1:0]       commit_value,
  input  logic [NUM_IN*XLEN-1:0]       commit_next_pc,
  input  logic [NUM_IN*RENAME_W-1:0]   commit_rename,
  input  logic [NUM_IN*5-1:0]          commit_dest,
  input  logic [NUM_IN-1:0]            commit_is_br,
  input  logic [NUM_IN-1:0]            commit_is_jalr,
  output logic                         commit_ready,
  output logic [NUM_OUT-1:0]           rs_valid,
  output logic [NUM_OUT-1:0]           reg_valid,
  output logic [NUM_OUT*RENAME_W-1:0]  bc_rename,
  output logic [NUM_OUT*XLEN-1:0]      bc_value,
  output logic [NUM_OUT*XLEN-1:0]      bc_reg_value,
  output logic [NUM_OUT*5-1:0]         bc_dest,
  output logic                         branch_commit,
  output logic                         branch_jump,
  output logic                         jalr_commit,
  output logic [XLEN-1:0]              jalr_addr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                is_br;
    logic                is_jalr;
    logic [4:0]          dest;
    logic [RENAME_W-1:0] rename;
    logic [XLEN-1:0]     next_pc;
    logic [XLEN-1:0]     value;
  } entry_t;

  entry_t             q [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  entry_t             in_ent [NUM_IN];
  entry_t             cand [NUM_OUT];
  logic [NUM_OUT-1:0] take;
  logic               stop;
  logic               accept;
  int                 n_valid;
  int                 n_acc;
  int                 n_out;
  int                 n_from_q;
  int                 n_byp;

  assign commit_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(NUM_IN);
  assign accept       = rdy && !flush && commit_ready;

  always_comb begin
    n_valid = 0;
    for (int j = 0; j < NUM_IN; j++) in_ent[j] = '0;
    // Compact valid lanes so the oldest valid commit lands in slot 0.
    for (int i = 0; i < NUM_IN; i++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (commit_valid[i] && n_valid == j) begin
          in_ent[j].is_br   = commit_is_br[i];
          in_ent[j].is_jalr = commit_is_jalr[i];
          in_ent[j].dest    = commit_dest[i*5 +: 5];
          in_ent[j].rename  = commit_rename[i*RENAME_W +: RENAME_W];
          in_ent[j].next_pc = commit_next_pc[i*XLEN +: XLEN];
          in_ent[j].value   = commit_value[i*XLEN +: XLEN];
        end
      end
      if (commit_valid[i]) n_valid = n_valid + 1;
    end
    n_acc = accept ? n_valid : 0;

    // Drain candidates: queued entries first, then same-cycle commits as bypass.
    stop  = 1'b0;
    n_out = 0;
    for (int s = 0; s < NUM_OUT; s++) begin
      cand[s] = '0;
      if (s < int'(count)) cand[s] = q[PTR_W'(int'(head) + s)];
      for (int j = 0; j < NUM_IN; j++)
        if (int'(count) + j == s) cand[s] = in_ent[j];
      take[s] = 1'b0;
      if (!stop && rdy && !flush && s < int'(count) + n_acc) begin
        take[s] = 1'b1;
        n_out   = n_out + 1;
        if (cand[s].is_br || cand[s].is_jalr) stop = 1'b1;
      end
    end
    n_from_q = (n_out < int'(count)) ? n_out : int'(count);
    n_byp    = n_out - n_from_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_IN; j++)
        if (j >= n_byp && j < n_acc)
          q[PTR_W'(int'(tail) + j - n_byp)] <= in_ent[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      rs_valid      <= '0;
      reg_valid     <= '0;
      bc_rename     <= '0;
      bc_value      <= '0;
      bc_reg_value  <= '0;
      bc_dest       <= '0;
      branch_commit <= 1'b0;
      branch_jump   <= 1'b0;
      jalr_commit   <= 1'b0;
      jalr_addr     <= '0;
    end else if (flush) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      rs_valid      <= '0;
      reg_valid     <= '0;
      branch_commit <= 1'b0;
      jalr_commit   <= 1'b0;
    end else if (!rdy) begin
      rs_valid      <= '0;
      reg_valid     <= '0;
      branch_commit <= 1'b0;
      jalr_commit   <= 1'b0;
    end else begin
      head          <= PTR_W'(int'(head) + n_from_q);
      tail          <= PTR_W'(int'(tail) + n_acc - n_byp);
      count         <= CNT_W'(int'(count) + n_acc - n_out);
      rs_valid      <= '0;
      reg_valid     <= '0;
      branch_commit <= 1'b0;
      jalr_commit   <= 1'b0;
      for (int s = 0; s < NUM_OUT; s++) begin
        if (take[s]) begin
          rs_valid[s]                       <= !(cand[s].is_br || cand[s].is_jalr);
          reg_valid[s]                      <= !cand[s].is_br;
          bc_rename[s*RENAME_W +: RENAME_W] <= cand[s].rename;
          bc_value[s*XLEN +: XLEN]          <= cand[s].value;
          bc_reg_value[s*XLEN +: XLEN]      <= cand[s].is_jalr ? cand[s].next_pc : cand[s].value;
          bc_dest[s*5 +: 5]                 <= cand[s].dest;
          if (cand[s].is_br) begin
            branch_commit <= 1'b1;
            branch_jump   <= cand[s].value[0];
          end
          if (cand[s].is_jalr) begin
            jalr_commit <= 1'b1;
            jalr_addr   <= cand[s].value;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_multi_bcast.sv
// tb/tb_cdb_multi_bcast.sv - directed self-checking bench for cdb_multi_bcast
module tb_cdb_multi_bcast;
  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [1:0]  commit_valid;
  logic [63:0] commit_value;
  logic [63:0] commit_next_pc;
  logic [7:0]  commit_rename;
  logic [9:0]  commit_dest;
  logic [1:0]  commit_is_br;
  logic [1:0]  commit_is_jalr;
  logic        commit_ready;
  logic [1:0]  rs_valid;
  logic [1:0]  reg_valid;
  logic [7:0]  bc_rename;
  logic [63:0] bc_value;
  logic [63:0] bc_reg_value;
  logic [9:0]  bc_dest;
  logic        branch_commit;
  logic        branch_jump;
  logic        jalr_commit;
  logic [31:0] jalr_addr;

  int n_chk;
  int n_fail;

  cdb_multi_bcast dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .commit_valid(commit_valid), .commit_value(commit_value),
    .commit_next_pc(commit_next_pc), .commit_rename(commit_rename),
    .commit_dest(commit_dest), .commit_is_br(commit_is_br),
    .commit_is_jalr(commit_is_jalr), .commit_ready(commit_ready),
    .rs_valid(rs_valid), .reg_valid(reg_valid), .bc_rename(bc_rename),
    .bc_value(bc_value), .bc_reg_value(bc_reg_value), .bc_dest(bc_dest),
    .branch_commit(branch_commit), .branch_jump(branch_jump),
    .jalr_commit(jalr_commit), .jalr_addr(jalr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    commit_valid   = '0;
    commit_value   = '0;
    commit_next_pc = '0;
    commit_rename  = '0;
    commit_dest    = '0;
    commit_is_br   = '0;
    commit_is_jalr = '0;
  endtask

  task automatic set_lane(input int l, input logic [3:0] tag, input logic [4:0] dst,
                          input logic [31:0] val, input logic [31:0] npc,
                          input logic br, input logic jr);
    commit_valid[l]          = 1'b1;
    commit_rename[l*4 +: 4]  = tag;
    commit_dest[l*5 +: 5]    = dst;
    commit_value[l*32 +: 32] = val;
    commit_next_pc[l*32 +: 32] = npc;
    commit_is_br[l]          = br;
    commit_is_jalr[l]        = jr;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    rdy    = 1'b1;
    flush  = 1'b0;
    clr();
    tick();
    tick();
    chk("reset_rs_valid", rs_valid, 0);
    chk("reset_reg_valid", reg_valid, 0);
    chk("reset_branch", branch_commit, 0);
    chk("reset_jalr", jalr_commit, 0);
    chk("reset_bc_value", bc_value, 0);
    chk("reset_jalr_addr", jalr_addr, 0);
    chk("reset_ready", commit_ready, 1);
    rst = 1'b1;

    // single normal commit, latency 1
    set_lane(0, 4'd3, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0);
    tick();
    clr();
    chk("t1_rs_valid", rs_valid, 2'b01);
    chk("t1_reg_valid", reg_valid, 2'b01);
    chk("t1_rename", bc_rename[3:0], 3);
    chk("t1_dest", bc_dest[4:0], 5);
    chk("t1_value", bc_value[31:0], 32'h1234);
    chk("t1_reg_value", bc_reg_value[31:0], 32'h1234);
    tick();
    chk("t1_rs_off", rs_valid, 0);
    chk("t1_reg_off", reg_valid, 0);

    // lane 1 only: compacted onto output lane 0
    set_lane(1, 4'd7, 5'd9, 32'h77, 32'h0, 1'b0, 1'b0);
    tick();
    clr();
    chk("cmp_rs_valid", rs_valid, 2'b01);
    chk("cmp_rename", bc_rename[3:0], 7);
    chk("cmp_dest", bc_dest[4:0], 9);

    // two normal lanes in one cycle
    set_lane(0, 4'd1, 5'd2, 32'hA1, 32'h0, 1'b0, 1'b0);
    set_lane(1, 4'd2, 5'd3, 32'hB2, 32'h0, 1'b0, 1'b0);
    tick();
    clr();
    chk("two_rs_valid", rs_valid, 2'b11);
    chk("two_rename", bc_rename, 8'h21);
    chk("two_value", bc_value, 64'h000000B2_000000A1);

    // jalr then branch: one control entry per cycle
    set_lane(0, 4'd4, 5'd1, 32'h80, 32'h14, 1'b0, 1'b1);
    set_lane(1, 4'd5, 5'd0, 32'h1, 32'h0, 1'b1, 1'b0);
    tick();
    clr();
    chk("t2_jalr_commit", jalr_commit, 1);
    chk("t2_jalr_addr", jalr_addr, 32'h80);
    chk("t2_reg_valid", reg_valid, 2'b01);
    chk("t2_reg_value", bc_reg_value[31:0], 32'h14);
    chk("t2_rs_valid", rs_valid, 0);
    chk("t2_branch_early", branch_commit, 0);
    tick();
    chk("t2_branch_commit", branch_commit, 1);
    chk("t2_branch_jump", branch_jump, 1);
    chk("t2_jalr_off", jalr_commit, 0);
    chk("t2_reg_off", reg_valid, 0);
    tick();
    chk("t2_branch_off", branch_commit, 0);

    // fill: jalr pairs drain one per cycle, so occupancy grows by one per cycle
    for (int k = 0; k < 7; k++) begin
      clr();
      set_lane(0, 4'(2*k), 5'd1, 32'h100 + 32'(2*k), 32'h400 + 32'(2*k), 1'b0, 1'b1);
      set_lane(1, 4'(2*k+1), 5'd1, 32'h100 + 32'(2*k+1), 32'h400 + 32'(2*k+1), 1'b0, 1'b1);
      tick();
      chk("fill_jalr", jalr_commit, 1);
      chk("fill_addr", jalr_addr, 32'h100 + 32'(k));
      chk("fill_ready", commit_ready, (k + 1 <= 6) ? 1 : 0);
    end
    clr();
    set_lane(0, 4'd14, 5'd1, 32'h10E, 32'h0, 1'b0, 1'b1);
    set_lane(1, 4'd15, 5'd1, 32'h10F, 32'h0, 1'b0, 1'b1);
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_jalr", jalr_commit, 0);
      chk("stall_addr_hold", jalr_addr, 32'h106);
      chk("stall_ready", commit_ready, 0);
    end
    rdy = 1'b1;
    tick();
    clr();
    chk("full_drop_addr", jalr_addr, 32'h107);
    chk("full_drop_jalr", jalr_commit, 1);
    chk("full_ready_back", commit_ready, 1);
    for (int t = 8; t < 14; t++) begin
      tick();
      chk("drain_addr", jalr_addr, 32'h100 + 32'(t));
      chk("drain_rename", bc_rename[3:0], 64'(t));
      chk("drain_reg_value", bc_reg_value[31:0], 32'h400 + 32'(t));
    end
    tick();
    chk("drain_done", jalr_commit, 0);
    chk("drain_reg_off", reg_valid, 0);

    // wrap: 1-entry backlog keeps the queue pointers moving through 20 entries
    set_lane(0, 4'd9, 5'd1, 32'h300, 32'h0, 1'b0, 1'b1);
    set_lane(1, 4'd0, 5'd2, 32'h200, 32'h0, 1'b0, 1'b0);
    tick();
    chk("wrap_jalr", jalr_commit, 1);
    chk("wrap_rs_first", rs_valid, 0);
    for (int k = 0; k < 10; k++) begin
      clr();
      set_lane(0, 4'(2*k+1), 5'd2, 32'h200 + 32'(2*k+1), 32'h0, 1'b0, 1'b0);
      if (k < 9) set_lane(1, 4'(2*k+2), 5'd2, 32'h200 + 32'(2*k+2), 32'h0, 1'b0, 1'b0);
      tick();
      chk("wrap_rs_valid", rs_valid, 2'b11);
      chk("wrap_rename", bc_rename, {4'(2*k+1), 4'(2*k)});
      chk("wrap_value1", bc_value[63:32], 32'h200 + 32'(2*k+1));
    end
    clr();
    tick();
    chk("wrap_done", rs_valid, 0);

    // flush with 5 entries queued
    for (int k = 0; k < 5; k++) begin
      clr();
      set_lane(0, 4'(2*k), 5'd1, 32'h500 + 32'(2*k), 32'h0, 1'b0, 1'b1);
      set_lane(1, 4'(2*k+1), 5'd1, 32'h500 + 32'(2*k+1), 32'h0, 1'b0, 1'b1);
      tick();
    end
    clr();
    set_lane(0, 4'hA, 5'd3, 32'hAA, 32'h0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clr();
    chk("flush_rs", rs_valid, 0);
    chk("flush_jalr", jalr_commit, 0);
    chk("flush_ready", commit_ready, 1);
    tick();
    chk("flush_empty_rs", rs_valid, 0);
    chk("flush_empty_reg", reg_valid, 0);
    chk("flush_empty_jalr", jalr_commit, 0);
    set_lane(0, 4'hB, 5'd4, 32'hBB, 32'h0, 1'b0, 1'b0);
    tick();
    clr();
    chk("post_flush_rs", rs_valid, 2'b01);
    chk("post_flush_rename", bc_rename[3:0], 4'hB);

    // async reset between edges with queue non-empty
    for (int k = 0; k < 3; k++) begin
      clr();
      set_lane(0, 4'(2*k), 5'd1, 32'h600 + 32'(2*k), 32'h0, 1'b0, 1'b1);
      set_lane(1, 4'(2*k+1), 5'd1, 32'h600 + 32'(2*k+1), 32'h0, 1'b0, 1'b1);
      tick();
    end
    clr();
    chk("pre_reset_jalr", jalr_commit, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_jalr", jalr_commit, 0);
    chk("areset_reg", reg_valid, 0);
    chk("areset_addr", jalr_addr, 0);
    chk("areset_ready", commit_ready, 1);
    #1;
    rst = 1'b1;
    tick();
    chk("areset_empty_jalr", jalr_commit, 0);
    chk("areset_empty_reg", reg_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
